// File: rtl/key_debounce_pkg.sv
// key_debounce shared constants and helpers.
// Autorepeat timing used when KEY_DEBOUNCE_AUTOREPEAT_EN is defined.
package key_debounce_pkg;

  localparam int REPEAT_DELAY_US  = 500000;
  localparam int REPEAT_PERIOD_US = 100000;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key bit: 2-FF sync, debounce counter, press/release pulses.
// KEY_DEBOUNCE_AUTOREPEAT_EN adds a typematic repeat counter.
module key_debounce_bit
  import key_debounce_pkg::*;
#(
  parameter int DB_CYCLES     = 1,
  parameter int ACTIVE_LOW    = 1
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 1,
  parameter int REPEAT_PERIOD = 1
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_sw,
  output logic key_press,
  output logic key_release
);

  localparam int CNT_W = clog2_min1(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DB_CYCLES - 1);
  localparam logic IDLE = (ACTIVE_LOW != 0);

  logic             r_s1;
  logic             r_s2;
  logic             r_sw;
  logic             r_press;
  logic             r_rel;
  logic [CNT_W-1:0] r_cnt;
  logic             w_lvl;
  logic             w_acc;

  // Sync holds the raw pin level; normalise after it.
  assign w_lvl = IDLE ? ~r_s2 : r_s2;
  assign w_acc = (w_lvl != r_sw) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1    <= IDLE;
      r_s2    <= IDLE;
      r_sw    <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= key_raw;
      r_s2    <= r_s1;
      r_press <= w_acc & w_lvl;
      r_rel   <= w_acc & ~w_lvl;
      if (w_lvl == r_sw) begin
        r_cnt <= '0;
      end else if (w_acc) begin
        r_sw  <= w_lvl;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign key_sw      = r_sw;
  assign key_release = r_rel;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  localparam int RD = (REPEAT_DELAY  < 1) ? 1 : REPEAT_DELAY;
  localparam int RP = (REPEAT_PERIOD < 1) ? 1 : REPEAT_PERIOD;
  localparam int RM = (RD > RP) ? RD : RP;
  localparam int REP_W = clog2_min1(RM + 1);

  logic [REP_W-1:0] r_rep;
  logic             r_first;
  logic             r_rpt;
  logic [REP_W-1:0] w_lim;

  assign w_lim = r_first ? REP_W'(RD - 1) : REP_W'(RP - 1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rep   <= '0;
      r_first <= 1'b1;
      r_rpt   <= 1'b0;
    end else begin
      r_rpt <= 1'b0;
      if (!r_sw || w_acc) begin
        r_rep   <= '0;
        r_first <= 1'b1;
      end else if (r_rep == w_lim) begin
        r_rep   <= '0;
        r_first <= 1'b0;
        r_rpt   <= 1'b1;
      end else begin
        r_rep <= r_rep + 1'b1;
      end
    end
  end

  assign key_press = r_press | r_rpt;
`else
  assign key_press = r_press;
`endif

endmodule

// File: rtl/key_debounce.sv
// Board key conditioner: per-bit sync + debounce + edge pulses.
// KEY_DEBOUNCE_AUTOREPEAT_EN enables typematic repeat on key_press.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int CLK_MHZ          = 50,
  parameter int KEY_WIDTH        = 4,
  parameter int DEBOUNCE_US      = 10000,
  parameter int ACTIVE_LOW       = 1
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_US  = key_debounce_pkg::REPEAT_DELAY_US,
  parameter int REPEAT_PERIOD_US = key_debounce_pkg::REPEAT_PERIOD_US
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] key_raw,
  output logic [KEY_WIDTH-1:0] key_sw,
  output logic [KEY_WIDTH-1:0] key_press,
  output logic [KEY_WIDTH-1:0] key_release
);

  localparam int DB_RAW    = CLK_MHZ * DEBOUNCE_US;
  localparam int DB_CYCLES = (DB_RAW < 1) ? 1 : DB_RAW;

  for (genvar g = 0; g < KEY_WIDTH; g++) begin : g_bit
    key_debounce_bit #(
      .DB_CYCLES    (DB_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
      ,
      .REPEAT_DELAY (CLK_MHZ * REPEAT_DELAY_US),
      .REPEAT_PERIOD(CLK_MHZ * REPEAT_PERIOD_US)
`endif
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .key_raw    (key_raw[g]),
      .key_sw     (key_sw[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce (DB_CYCLES = 8, active-low keys).
// Repeat checks compile in with KEY_DEBOUNCE_AUTOREPEAT_EN.
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] key_raw = 4'b1111;
  logic [3:0] key_sw;
  logic [3:0] key_press;
  logic [3:0] key_release;

  int total = 0;
  int bad   = 0;

  key_debounce #(
    .CLK_MHZ         (1),
    .KEY_WIDTH       (4),
    .DEBOUNCE_US     (8),
    .ACTIVE_LOW      (1)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY_US (20),
    .REPEAT_PERIOD_US(6)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .key_sw     (key_sw),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [3:0] acc;
  logic [3:0] both;
  logic       e;

  initial begin
    reset   = 1'b0;
    key_raw = 4'b1111;
    ticks(3);
    chk("rst_sw",  {28'd0, key_sw},      32'd0);
    chk("rst_prs", {28'd0, key_press},   32'd0);
    chk("rst_rel", {28'd0, key_release}, 32'd0);
    reset = 1'b1;
    ticks(2);

    key_raw = 4'b1110;
    ticks(9);
    chk("prs_e9_sw",  {28'd0, key_sw},    32'd0);
    chk("prs_e9_prs", {28'd0, key_press}, 32'd0);
    tick();
    chk("prs_e10_sw",  {28'd0, key_sw},      32'd1);
    chk("prs_e10_prs", {28'd0, key_press},   32'd1);
    chk("prs_e10_rel", {28'd0, key_release}, 32'd0);
    tick();
    chk("prs_e11_prs", {28'd0, key_press}, 32'd0);
    ticks(3);
    chk("prs_hold_sw", {28'd0, key_sw}, 32'd1);

    acc = '0;
    for (int i = 0; i < 42; i++) begin
      key_raw[1] = ((i % 6) == 5);
      tick();
      acc = acc | key_press | key_release | (key_sw & 4'b1110);
    end
    chk("bnc_quiet", {28'd0, acc}, 32'd0);
    key_raw[1] = 1'b0;
    ticks(9);
    chk("bnc_e9_sw", {28'd0, key_sw}, 32'd1);
    tick();
    chk("bnc_e10_sw",  {28'd0, key_sw},    32'd3);
    chk("bnc_e10_prs", {28'd0, key_press}, 32'd2);
    ticks(2);
    chk("bnc_e12_sw", {28'd0, key_sw}, 32'd3);

    key_raw[0] = 1'b1;
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      acc = acc | key_press | key_release;
    end
    chk("rel_e9_quiet", {28'd0, acc},    32'd0);
    chk("rel_e9_sw",    {28'd0, key_sw}, 32'd3);
    tick();
    chk("rel_e10_rel", {28'd0, key_release}, 32'd1);
    chk("rel_e10_sw",  {28'd0, key_sw},      32'd2);
    chk("rel_e10_prs", {28'd0, key_press},   32'd0);
    tick();
    chk("rel_e11_rel", {28'd0, key_release}, 32'd0);

    key_raw = 4'b1111;
    ticks(14);
    chk("idle_sw", {28'd0, key_sw}, 32'd0);

    key_raw = 4'b0000;
    acc  = '0;
    both = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      acc = acc | key_release | key_press;
    end
    chk("sim_e9_quiet", {28'd0, acc},    32'd0);
    chk("sim_e9_sw",    {28'd0, key_sw}, 32'd0);
    tick();
    chk("sim_e10_sw",  {28'd0, key_sw},      32'hf);
    chk("sim_e10_prs", {28'd0, key_press},   32'hf);
    chk("sim_e10_rel", {28'd0, key_release}, 32'd0);
    key_raw = 4'b1111;
    acc = '0;
    for (int i = 0; i < 14; i++) begin
      tick();
      acc  = acc | key_release;
      both = both | (key_press & key_release);
    end
    chk("sim_rel_all", {28'd0, acc},    32'hf);
    chk("sim_rel_sw",  {28'd0, key_sw}, 32'd0);
    chk("no_both",     {28'd0, both},   32'd0);

    key_raw = 4'b1011;
    ticks(5);
    reset = 1'b0;
    tick();
    chk("mid_rst_sw",  {28'd0, key_sw},    32'd0);
    chk("mid_rst_prs", {28'd0, key_press}, 32'd0);
    reset = 1'b1;
    ticks(9);
    chk("mid_e9_sw", {28'd0, key_sw}, 32'd0);
    tick();
    chk("mid_e10_prs", {28'd0, key_press}, 32'd4);
    chk("mid_e10_sw",  {28'd0, key_sw},    32'd4);
    key_raw = 4'b1111;
    ticks(14);

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    key_raw = 4'b0111;
    ticks(10);
    chk("rpt_first", {28'd0, key_press}, 32'd8);
    for (int k = 1; k <= 32; k++) begin
      tick();
      e = (k == 20) || (k == 26) || (k == 32);
      if (key_press[3] !== e) chk("rpt_seq", k, 32'd0);
    end
    chk("rpt_done", 32'd1, 32'd1 & {31'd0, key_sw[3]});
    key_raw = 4'b1111;
    ticks(10);
    chk("rpt_rel", {28'd0, key_release}, 32'd8);
    acc = '0;
    for (int i = 0; i < 30; i++) begin
      tick();
      acc = acc | key_press;
    end
    chk("rpt_none", {28'd0, acc}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
